mulchan_rd_req_ctrl: RTL and testbench



---
 rtl/mulchan_rd_pkg.sv | 30 +++
 rtl/mulchan_rd_req_ctrl_rr_arbiter.sv | 29 ++
 rtl/mulchan_rd_req_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mulchan_rd_req_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mulchan_rd_pkg.sv
// Shared types and helpers for the multi-channel read-request controller.
package mulchan_rd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // Widest packed per-channel bus the slice helper accepts.
  localparam int unsigned SLICE_BUS_W = 1024;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Field idx of width w from a bus packed with field 0 in the LSBs.
  function automatic logic [31:0] slice_extract(input logic [SLICE_BUS_W-1:0] bus,
                                                input int unsigned idx,
                                                input int unsigned w);
    logic [SLICE_BUS_W-1:0] sh;
    sh = bus >> (idx * w);
    return sh[31:0] & ~(32'hFFFF_FFFF << w);
  endfunction

endpackage

// File: rtl/mulchan_rd_req_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel at or after ptr.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    elig,
  input  logic [ID_W-1:0] ptr,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  int idx;

  // Scan from the far end so the closest match to ptr is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= int'(N)) idx = idx - int'(N);
      if (elig[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mulchan_rd_req_ctrl.sv
// Multi-channel read-request generator: per-channel credit and ring addressing,
// round-robin pick, one burst request at a time over a valid/ready handshake.
module mulchan_rd_req_ctrl
  import mulchan_rd_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned AXI_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned CNT_WIDTH  = 11,
  parameter int unsigned FIFO_CAP   = 1024,
  parameter int unsigned MAX_OUT    = 2,
  parameter int unsigned ID_WIDTH   = clog2(CH_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CH_NUM-1:0]               ch_enable,
  input  logic [CH_NUM-1:0]               ch_restart,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]    ch_beg_addr,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]    ch_end_addr,
  input  logic [CH_NUM*8-1:0]             ch_burst_len,
  input  logic [CH_NUM*CNT_WIDTH-1:0]     ch_fifo_cnt,
  input  logic [CNT_WIDTH-1:0]            watermark,
  output logic                            req_valid,
  input  logic                            req_ready,
  output logic [ADDR_WIDTH-1:0]           req_addr,
  output logic [7:0]                      req_len,
  output logic [ID_WIDTH-1:0]             req_id,
  input  logic                            done,
  input  logic [ID_WIDTH-1:0]             done_id,
  output logic [CH_NUM-1:0]               ch_busy,
  output logic                            err_underflow,
  output state_e                          dbg_state
);

  localparam int unsigned CW  = CNT_WIDTH + 2;
  localparam int unsigned AW1 = ADDR_WIDTH + 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [7:0]              req_len_q, req_len_d;
  logic [ID_WIDTH-1:0]     req_id_q, req_id_d, rr_ptr_q, rr_ptr_d;
  logic                    err_q, err_d;
  logic [CH_NUM-1:0]       busy_q, busy_d;

  logic [ADDR_WIDTH-1:0]   addr_q [CH_NUM];
  logic [ADDR_WIDTH-1:0]   addr_d [CH_NUM];
  logic [2:0]              oc_q [CH_NUM];
  logic [2:0]              oc_d [CH_NUM];
  logic [CW-1:0]           ob_q [CH_NUM];
  logic [CW-1:0]           ob_d [CH_NUM];
  logic [7:0]              len_lat_q [CH_NUM];
  logic [7:0]              len_lat_d [CH_NUM];

  logic [ADDR_WIDTH-1:0]   beg_a [CH_NUM];
  logic [ADDR_WIDTH-1:0]   end_a [CH_NUM];
  logic [7:0]              blen [CH_NUM];
  logic [CNT_WIDTH-1:0]    fcnt [CH_NUM];
  logic [7:0]              eff_len [CH_NUM];
  logic [CW-1:0]           credit [CH_NUM];
  logic [CH_NUM-1:0]       elig, acc_hit, don_hit;

  logic                    grant_valid, accept;
  logic [ID_WIDTH-1:0]     grant_id;
  logic [CW-1:0]           req_rlen;
  logic [AW1-1:0]          inc, nxt, last;
  logic [ADDR_WIDTH-1:0]   wrap_addr;

  // An idle channel follows ch_burst_len; once bursts are in flight the latched length is used.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      beg_a[i]   = ADDR_WIDTH'(slice_extract(SLICE_BUS_W'(ch_beg_addr), i, ADDR_WIDTH));
      end_a[i]   = ADDR_WIDTH'(slice_extract(SLICE_BUS_W'(ch_end_addr), i, ADDR_WIDTH));
      blen[i]    = 8'(slice_extract(SLICE_BUS_W'(ch_burst_len), i, 8));
      fcnt[i]    = CNT_WIDTH'(slice_extract(SLICE_BUS_W'(ch_fifo_cnt), i, CNT_WIDTH));
      eff_len[i] = (oc_q[i] == '0) ? blen[i] : len_lat_q[i];
      credit[i]  = CW'(fcnt[i]) + ob_q[i] + CW'(eff_len[i]) + CW'(1);
      elig[i]    = ch_enable[i] && (oc_q[i] < 3'(MAX_OUT)) && (fcnt[i] < watermark) &&
                   (credit[i] <= CW'(FIFO_CAP));
    end
  end

  rr_arbiter #(.N(CH_NUM), .ID_W(ID_WIDTH)) u_arb (
    .elig        (elig),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Handshake: req_valid rises the cycle after a pick and stays high with
  // req_addr/len/id frozen until the cycle where req_valid && req_ready (the accept).
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_len_d  = req_len_q;
    req_id_d   = req_id_q;
    rr_ptr_d   = rr_ptr_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_addr_d = addr_q[grant_id];
          req_len_d  = eff_len[grant_id];
          req_id_d   = grant_id;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (req_ready) begin
          accept   = 1'b1;
          state_d  = IDLE;
          rr_ptr_d = (req_id_q == ID_WIDTH'(CH_NUM - 1)) ? '0 : req_id_q + ID_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ring wrap: restart at beg when the following burst would run past end.
  always_comb begin
    req_rlen  = CW'(req_len_q) + CW'(1);
    inc       = (AW1'(req_len_q) + AW1'(1)) * AW1'(AXI_WIDTH / 8);
    nxt       = {1'b0, addr_q[req_id_q]} + inc;
    last      = nxt + inc - AW1'(1);
    wrap_addr = (last > {1'b0, end_a[req_id_q]}) ? beg_a[req_id_q] : nxt[ADDR_WIDTH-1:0];
  end

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < CH_NUM; i++) begin
      acc_hit[i] = accept && (req_id_q == ID_WIDTH'(i));
      don_hit[i] = done && (done_id == ID_WIDTH'(i)) && (oc_q[i] != '0);
      if (done && (done_id == ID_WIDTH'(i)) && (oc_q[i] == '0)) err_d = 1'b1;
      if (acc_hit[i] && !don_hit[i])      oc_d[i] = oc_q[i] + 3'd1;
      else if (!acc_hit[i] && don_hit[i]) oc_d[i] = oc_q[i] - 3'd1;
      else                                oc_d[i] = oc_q[i];
      ob_d[i] = ob_q[i] + (acc_hit[i] ? req_rlen : '0) -
                (don_hit[i] ? (CW'(len_lat_q[i]) + CW'(1)) : '0);
      len_lat_d[i] = acc_hit[i] ? req_len_q : ((oc_q[i] == '0) ? blen[i] : len_lat_q[i]);
      addr_d[i] = addr_q[i];
      if (acc_hit[i])    addr_d[i] = wrap_addr;
      if (ch_restart[i]) addr_d[i] = beg_a[i];
      busy_d[i] = (oc_q[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_len_q  <= '0;
      req_id_q   <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
      busy_q     <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        addr_q[i]    <= beg_a[i];
        oc_q[i]      <= '0;
        ob_q[i]      <= '0;
        len_lat_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_len_q  <= req_len_d;
      req_id_q   <= req_id_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      for (int i = 0; i < CH_NUM; i++) begin
        addr_q[i]    <= addr_d[i];
        oc_q[i]      <= oc_d[i];
        ob_q[i]      <= ob_d[i];
        len_lat_q[i] <= len_lat_d[i];
      end
    end
  end

  assign req_valid     = (state_q == REQ);
  assign req_addr      = req_addr_q;
  assign req_len       = req_len_q;
  assign req_id        = req_id_q;
  assign ch_busy       = busy_q;
  assign err_underflow = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mulchan_rd_req_ctrl.sv
// Bench for mulchan_rd_req_ctrl: expected bursts queued per test, compared on accept.
module tb_mulchan_rd_req_ctrl;

  localparam int DONE_LAT = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   ch_enable = '0;
  logic [3:0]   ch_restart = '0;
  logic [119:0] ch_beg_addr, ch_end_addr;
  logic [31:0]  ch_burst_len;
  logic [43:0]  ch_fifo_cnt = '0;
  logic [10:0]  watermark = 11'd512;
  logic         req_valid, req_ready = 1'b0;
  logic [29:0]  req_addr;
  logic [7:0]   req_len;
  logic [1:0]   req_id;
  logic         done = 1'b0;
  logic [1:0]   done_id = '0;
  logic [3:0]   ch_busy;
  logic         err_underflow;
  mulchan_rd_pkg::state_e dbg_state;

  mulchan_rd_req_ctrl dut (
    .clk (clk), .rst (rst), .ch_enable (ch_enable), .ch_restart (ch_restart),
    .ch_beg_addr (ch_beg_addr), .ch_end_addr (ch_end_addr), .ch_burst_len (ch_burst_len),
    .ch_fifo_cnt (ch_fifo_cnt), .watermark (watermark), .req_valid (req_valid),
    .req_ready (req_ready), .req_addr (req_addr), .req_len (req_len), .req_id (req_id),
    .done (done), .done_id (done_id), .ch_busy (ch_busy), .err_underflow (err_underflow),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: {id, len, addr} per expected accept.
  logic [39:0] exp_q[$];
  int          due_q[$];
  logic [1:0]  did_q[$];
  int          out_m[4];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          auto_done = 1'b0;

  typedef struct {
    int fifo;
    int wm;
    int len;
    int n;
    int addr1;
  } cred_t;
  cred_t tbl[9];

  function automatic logic [39:0] mk(input logic [1:0] id, input logic [7:0] len,
                                     input logic [29:0] addr);
    return {id, len, addr};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [39:0] e;
    @(negedge clk);
    if (req_valid && req_ready && !rst) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_accept: got id=%0d addr=%0h, required no request", req_id, req_addr);
      end else begin
        e = exp_q.pop_front();
        check("accept_id", req_id, e[39:38]);
        check("accept_len", req_len, e[37:30]);
        check("accept_addr", req_addr, e[29:0]);
      end
      check("max_out", out_m[req_id] < 2, 1);
      out_m[req_id]++;
      if (auto_done) begin
        due_q.push_back(cyc + DONE_LAT);
        did_q.push_back(req_id);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    done = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      done_id = did_q.pop_front();
      done = 1'b1;
      if (out_m[done_id] > 0) out_m[done_id]--;
    end
  endtask

  task automatic do_done(input logic [1:0] id);
    done = 1'b1;
    done_id = id;
    if (out_m[id] > 0) out_m[id]--;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    did_q.delete();
    for (int i = 0; i < 4; i++) out_m[i] = 0;
    auto_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      step();
      c++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (!req_valid && c < budget) begin
      step();
      c++;
    end
    check("wait_valid", req_valid, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ch_beg_addr[i*30 +: 30]  = 30'(i * 'h1000);
      ch_end_addr[i*30 +: 30]  = 30'(i * 'h1000 + 'h7FF);
      ch_burst_len[i*8 +: 8]   = 8'd15;
    end
    tbl[0] = '{1009, 1024, 15, 0, 0};
    tbl[1] = '{1008, 1024, 15, 1, 0};
    tbl[2] = '{1000, 1024, 15, 1, 0};
    tbl[3] = '{512, 512, 15, 0, 0};
    tbl[4] = '{511, 512, 15, 2, 'h80};
    tbl[5] = '{0, 1024, 255, 2, 0};
    tbl[6] = '{600, 1024, 255, 1, 0};
    tbl[7] = '{800, 1024, 255, 0, 0};
    tbl[8] = '{0, 0, 15, 0, 0};

    // Reset values
    do_reset();
    check("rst_valid", req_valid, 0);
    check("rst_addr", req_addr, 0);
    check("rst_len", req_len, 0);
    check("rst_id", req_id, 0);
    check("rst_busy", ch_busy, 0);
    check("rst_err", err_underflow, 0);
    check("rst_state", dbg_state, mulchan_rd_pkg::IDLE);

    // Single channel ring walk with delayed completions
    ch_enable = 4'b0001;
    req_ready = 1'b1;
    do_reset();
    auto_done = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(mk(2'd0, 8'd15, 30'(k * 'h80)));
    exp_q.push_back(mk(2'd0, 8'd15, 30'h0));
    wait_drain(1000);
    ch_enable = 4'b0000;
    repeat (20) step();
    check("ring_busy_idle", ch_busy, 4'b0000);
    check("ring_err", err_underflow, 0);

    // Round robin across all channels, no completions
    ch_enable = 4'b1111;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back(mk(2'(c), 8'd15, 30'(c * 'h1000 + r * 'h80)));
    wait_drain(200);
    repeat (20) step();
    check("rr_busy_all", ch_busy, 4'b1111);

    // Credit and watermark table on channel 0
    for (int t = 0; t < 9; t++) begin
      ch_enable = 4'b0001;
      ch_fifo_cnt[10:0] = 11'(tbl[t].fifo);
      watermark = 11'(tbl[t].wm);
      ch_burst_len[7:0] = 8'(tbl[t].len);
      do_reset();
      if (tbl[t].n > 0) exp_q.push_back(mk(2'd0, 8'(tbl[t].len), 30'h0));
      if (tbl[t].n > 1) exp_q.push_back(mk(2'd0, 8'(tbl[t].len), 30'(tbl[t].addr1)));
      wait_drain(50);
      repeat (12) step();
      check("credit_busy", ch_busy[0], tbl[t].n > 0);
    end
    ch_fifo_cnt = '0;
    watermark = 11'd512;
    ch_burst_len[7:0] = 8'd15;

    // Request held while ready is low; enable and watermark drop ignored
    ch_enable = 4'b0010;
    req_ready = 1'b0;
    do_reset();
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      ch_enable = 4'b0000;
      watermark = 11'd0;
      step();
      check("hold_valid", req_valid, 1);
      check("hold_id", req_id, 1);
      check("hold_addr", req_addr, 30'h1000);
      check("hold_len", req_len, 15);
    end
    exp_q.push_back(mk(2'd1, 8'd15, 30'h1000));
    req_ready = 1'b1;
    wait_drain(5);
    repeat (10) step();
    check("hold_no_more", req_valid, 0);
    watermark = 11'd512;

    // Done and accept on channel 2 in the same cycle, then underflow on channel 3
    ch_enable = 4'b0100;
    do_reset();
    exp_q.push_back(mk(2'd2, 8'd15, 30'h2000));
    wait_drain(10);
    req_ready = 1'b0;
    wait_valid(10);
    exp_q.push_back(mk(2'd2, 8'd15, 30'h2080));
    req_ready = 1'b1;
    do_done(2'd2);
    step();
    exp_q.push_back(mk(2'd2, 8'd15, 30'h2100));
    wait_drain(10);
    repeat (12) step();
    check("same_cycle_busy", ch_busy, 4'b0100);
    check("uf_before", err_underflow, 0);
    do_done(2'd3);
    step();
    check("uf_set", err_underflow, 1);
    repeat (5) step();
    check("uf_sticky", err_underflow, 1);

    // Restart during outstanding bursts, then reset while a request is pending
    ch_enable = 4'b0001;
    do_reset();
    exp_q.push_back(mk(2'd0, 8'd15, 30'h000));
    exp_q.push_back(mk(2'd0, 8'd15, 30'h080));
    wait_drain(10);
    repeat (5) step();
    ch_restart = 4'b0001;
    step();
    ch_restart = 4'b0000;
    req_ready = 1'b0;
    do_done(2'd0);
    step();
    wait_valid(10);
    check("restart_addr", req_addr, 30'h0);
    check("restart_id", req_id, 0);
    ch_enable = 4'b0000;
    rst = 1'b1;
    step();
    check("midrst_valid", req_valid, 0);
    check("midrst_addr", req_addr, 0);
    check("midrst_len", req_len, 0);
    check("midrst_id", req_id, 0);
    check("midrst_busy", ch_busy, 0);
    check("midrst_err", err_underflow, 0);
    rst = 1'b0;
    req_ready = 1'b1;
    do_done(2'd0);
    step();
    check("late_done_err", err_underflow, 1);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
